multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Registered ALU for the multicycle RISC-V datapath. It sits directly downstream of the ALU control unit and consumes the operation code that unit produces, together with the two operands selected by the ALUSrc muxes. Add, subtract, logic and branch-compare operations complete in one cycle. Shifts are iterative, one bit per cycle. The result and branch condition are held in output registers (ALUOut/bcond) until the next operation completes.

## Interface
- DATA_WIDTH, 32, operand and result width; shift amount is in_b[4:0]
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only when busy=0
- alu_op  input  4  operation: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 XOR, 5 OR, 6 AND, 7 BEQ, 8 BNE, 9 BLT, 10 BGE, 11–15 reserved
- in_a  input  DATA_WIDTH  operand A
- in_b  input  DATA_WIDTH  operand B
- busy  output  1  high while a shift is iterating
- done  output  1  one-cycle pulse: alu_result/alu_bcond updated
- alu_result  output  DATA_WIDTH  registered result
- alu_bcond  output  1  registered branch condition

## Operation
- **States:** IDLE and SHIFT.
- **Capture:** alu_op, in_a and in_b are captured only on the accepting edge. Later changes to them are ignored.
- **IDLE, start=1, single-cycle op** (everything except SLL/SRL with shamt≥1):
  - alu_result ← f(a,b); alu_bcond updated; done←1; stay in IDLE.
- **IDLE, start=1, SLL/SRL with shamt=in_b[4:0]≥1:**
  - Shift register ← in_a; counter ← shamt; busy←1; go to SHIFT.
- **SHIFT state, each edge:**
  - Shift register shifts one bit (SLL left, zero fill; SRL logical right, zero fill); counter decrements.
  - On the edge where the counter goes 1→0: alu_result ← shifted value, alu_bcond←0, done←1, busy←0, go to IDLE.
- **SLL/SRL with shamt=0:** single-cycle; result = in_a.
- **Arithmetic rules:**
  - ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
  - in_b[31:5] is ignored for shifts.
  - Logic ops are bitwise.
- **Branch ops:**
  - alu_result = a−b (wrapped).
  - alu_bcond: BEQ a==b; BNE a!=b; BLT signed a<b; BGE signed a>=b.
  - All non-branch ops write alu_bcond=0.
- **Reserved alu_op:** single-cycle; alu_result←0, alu_bcond←0, done pulses.
- **start while busy=1:** ignored and not queued; the upstream must hold the request until busy=0.
- **start with no request pending:** when start=0 in IDLE, done←0 and the outputs hold their values.

## Timing
- **Reset values:** alu_result=0, alu_bcond=0, done=0, busy=0, state IDLE, counter=0.
  - Reset takes effect immediately and asynchronously, including mid-shift.
  - An interrupted shift produces no done and is lost.
- **Latency from accepting edge E0:**
  - Single-cycle op: done high in the cycle after E0.
  - Shift by n≥1: busy high in the cycles after E0 through E0+n−1; done high in the cycle after E0+n. Worst case is n=31.
- **done:** exactly one cycle wide per accepted request.
- **busy vs done:** busy falls on the same edge that done rises, so busy and done are never both 1.
- **Back-to-back requests:** a start asserted during the done cycle is accepted on that edge. Single-cycle ops therefore sustain one result per cycle.
- **Output stability:** alu_result and alu_bcond change only on edges that raise done (or on reset). They are stable between done pulses.

## Test plan
- **Reset mid-shift:** release reset, issue SLL in_a=1, in_b=20. Pull reset low 5 cycles after accept → immediately alu_result=0, busy=0, done=0. After release, no done pulse ever appears.
- **Back-to-back single-cycle ops:** ADD 0xFFFFFFFF+1, SUB 5−7, XOR 0xF0F0F0F0^0xFF00FF00, AND, OR, one per cycle → done high 4+ consecutive cycles. Results in order: 0x00000000, 0xFFFFFFFE, 0x0FF00FF0, correct AND/OR values.
- **SRL with ignored start:** SRL in_a=0x80000000, in_b=0x0000003F (shamt 31) → busy for 31 cycles. done in the 32nd cycle after accept with 0x00000001. A start pulsed mid-shift is ignored.
- **SLL corner cases:** SLL in_a=0x00000003, in_b=1 → done 1 cycle after busy, result 0x00000006. SLL shamt=0 → single-cycle, result 0x00000003.
- **Branch compares:** BLT a=0xFFFFFFFF(−1), b=1 → bcond=1. BGE same operands → bcond=0. BEQ 7,7 → bcond=1, result 0. BNE 7,7 → bcond=0. A following ADD → bcond=0.
- **Reserved op and hold:** alu_op=13 → done pulse, result 0, bcond 0. Then start=0 for 10 cycles → outputs hold, done stays 0.

Source files
------------

// File: rtl/multicycle_alu.sv
// Registered ALU for the multicycle RISC-V datapath: single-cycle add/sub/logic/compare,
// iterative one-bit-per-cycle shifts, results held in ALUOut/bcond until the next completion.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; single-cycle ops complete on the accepting edge
// S_SHIFT | iterating a shift, counter counts down to terminal count 1
module multicycle_alu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [3:0]            alu_op_i,
   input  logic [DATA_WIDTH-1:0] in_a_i,
   input  logic [DATA_WIDTH-1:0] in_b_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] alu_result_o,
   output logic                  alu_bcond_o
);

   localparam int SHW = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SLL = 4'd2;
   localparam logic [3:0] OP_SRL = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_BEQ = 4'd7;
   localparam logic [3:0] OP_BNE = 4'd8;
   localparam logic [3:0] OP_BLT = 4'd9;
   localparam logic [3:0] OP_BGE = 4'd10;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [SHW-1:0]        cnt_q, cnt_d;
   logic                  left_q, left_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  bcond_q, bcond_d;
   logic                  done_q, done_d;

   logic [SHW-1:0]        shamt;
   logic                  is_shift;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] imm_result;
   logic                  imm_bcond;
   logic [DATA_WIDTH-1:0] shreg_nxt;

   assign shamt     = in_b_i[SHW-1:0];
   assign is_shift  = (alu_op_i == OP_SLL) || (alu_op_i == OP_SRL);
   assign diff      = in_a_i - in_b_i;
   assign shreg_nxt = left_q ? (shreg_q << 1) : (shreg_q >> 1);

   // Only zero-distance shifts reach the single-cycle path, so they pass operand A through.
   always_comb begin
      imm_result = '0;
      imm_bcond  = 1'b0;
      case (alu_op_i)
         OP_ADD:  imm_result = in_a_i + in_b_i;
         OP_SUB:  imm_result = diff;
         OP_SLL,
         OP_SRL:  imm_result = in_a_i;
         OP_XOR:  imm_result = in_a_i ^ in_b_i;
         OP_OR:   imm_result = in_a_i | in_b_i;
         OP_AND:  imm_result = in_a_i & in_b_i;
         OP_BEQ: begin
            imm_result = diff;
            imm_bcond  = (in_a_i == in_b_i);
         end
         OP_BNE: begin
            imm_result = diff;
            imm_bcond  = (in_a_i != in_b_i);
         end
         OP_BLT: begin
            imm_result = diff;
            imm_bcond  = ($signed(in_a_i) < $signed(in_b_i));
         end
         OP_BGE: begin
            imm_result = diff;
            imm_bcond  = ($signed(in_a_i) >= $signed(in_b_i));
         end
         default: begin
            imm_result = '0;
            imm_bcond  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         result_q <= '0;
         bcond_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         result_q <= result_d;
         bcond_q  <= bcond_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      result_d = result_q;
      bcond_d  = bcond_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (is_shift && (shamt != '0)) begin
                  shreg_d = in_a_i;
                  cnt_d   = shamt;
                  left_d  = (alu_op_i == OP_SLL);
                  state_d = S_SHIFT;
               end else begin
                  result_d = imm_result;
                  bcond_d  = imm_bcond;
                  done_d   = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            shreg_d = shreg_nxt;
            cnt_d   = cnt_q - SHW'(1);
            // Terminal count: this edge takes the counter 1 -> 0 and publishes the result.
            if (cnt_q == SHW'(1)) begin
               result_d = shreg_nxt;
               bcond_d  = 1'b0;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o       = (state_q == S_SHIFT);
      done_o       = done_q;
      alu_result_o = result_q;
      alu_bcond_o  = bcond_q;
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: requests push expected results to a queue,
// each done pulse pops and compares them.
module tb_multicycle_alu;

   logic        clk_i    = 1'b0;
   logic        rst_ni   = 1'b0;
   logic        start_i  = 1'b0;
   logic [3:0]  alu_op_i = 4'd0;
   logic [31:0] in_a_i   = 32'd0;
   logic [31:0] in_b_i   = 32'd0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] alu_result_o;
   logic        alu_bcond_o;

   multicycle_alu #(.DATA_WIDTH(32)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .alu_op_i     (alu_op_i),
      .in_a_i       (in_a_i),
      .in_b_i       (in_b_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .alu_result_o (alu_result_o),
      .alu_bcond_o  (alu_bcond_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] res;
      logic        bc;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp = '0;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk_i);
      #1;
      chk({tag, "_excl"}, {31'd0, busy_o & done_o}, 32'd0);
      if (done_o === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s_unexpected_done observed=done expected=no_pending_request", tag);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, alu_result_o, e.res);
            chk({tag, "_bcond"}, {31'd0, alu_bcond_o}, {31'd0, e.bc});
            last_exp = e;
         end
      end
   endtask

   task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic bc);
      exp_t e;
      start_i  = 1'b1;
      alu_op_i = op;
      in_a_i   = a;
      in_b_i   = b;
      e.res    = res;
      e.bc     = bc;
      sb.push_back(e);
   endtask

   initial begin
      bit seen;

      // Reset values
      #1;
      chk("rst_result", alu_result_o, 32'd0);
      chk("rst_bcond", {31'd0, alu_bcond_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      tick("rst");
      tick("rst");
      rst_ni = 1'b1;
      tick("idle0");
      chk("idle0_done", {31'd0, done_o}, 32'd0);

      // Back-to-back single-cycle ops
      req(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0);
      tick("add");
      chk("add_done", {31'd0, done_o}, 32'd1);
      req(4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
      tick("sub");
      chk("sub_done", {31'd0, done_o}, 32'd1);
      req(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
      tick("xor");
      chk("xor_done", {31'd0, done_o}, 32'd1);
      req(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
      tick("and");
      chk("and_done", {31'd0, done_o}, 32'd1);
      req(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
      tick("or");
      chk("or_done", {31'd0, done_o}, 32'd1);
      start_i = 1'b0;
      tick("b2b_end");
      chk("b2b_end_done", {31'd0, done_o}, 32'd0);

      // SLL by 1 and by 0
      req(4'd2, 32'h0000_0003, 32'd1, 32'h0000_0006, 1'b0);
      tick("sll1_acc");
      chk("sll1_busy", {31'd0, busy_o}, 32'd1);
      chk("sll1_nodone", {31'd0, done_o}, 32'd0);
      start_i = 1'b0;
      tick("sll1");
      chk("sll1_done", {31'd0, done_o}, 32'd1);
      chk("sll1_busy_low", {31'd0, busy_o}, 32'd0);
      req(4'd2, 32'h0000_0003, 32'hFFFF_FFE0, 32'h0000_0003, 1'b0);
      tick("sll0");
      chk("sll0_done", {31'd0, done_o}, 32'd1);
      chk("sll0_busy", {31'd0, busy_o}, 32'd0);
      start_i = 1'b0;

      // SRL by 31 with an ignored start mid-shift
      req(4'd3, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0);
      tick("srl_acc");
      start_i = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         if (k == 10) begin
            start_i  = 1'b1;
            alu_op_i = 4'd0;
            in_a_i   = 32'd1;
            in_b_i   = 32'd1;
         end
         if (k == 11) start_i = 1'b0;
         tick("srl");
         if (done_o === 1'b1) begin
            seen = 1'b1;
            chk("srl_latency", k, 32'd31);
         end else if (k < 31) begin
            chk("srl_busy", {31'd0, busy_o}, 32'd1);
         end
      end
      if (!seen) chk("srl_timeout", 32'd0, 32'd1);
      start_i = 1'b0;
      tick("srl_after");
      chk("srl_hold", alu_result_o, 32'h0000_0001);

      // Reset mid-shift discards the shift
      start_i  = 1'b1;
      alu_op_i = 4'd2;
      in_a_i   = 32'd1;
      in_b_i   = 32'd20;
      tick("rsh_acc");
      start_i = 1'b0;
      repeat (5) tick("rsh");
      #2 rst_ni = 1'b0;
      #1;
      chk("rsh_result", alu_result_o, 32'd0);
      chk("rsh_busy", {31'd0, busy_o}, 32'd0);
      chk("rsh_done", {31'd0, done_o}, 32'd0);
      #1 rst_ni = 1'b1;
      last_exp = '0;
      repeat (30) tick("rsh_after");
      chk("rsh_after_busy", {31'd0, busy_o}, 32'd0);
      chk("rsh_after_result", alu_result_o, 32'd0);

      // Branch compares, back to back
      req(4'd9, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1);
      tick("blt");
      chk("blt_done", {31'd0, done_o}, 32'd1);
      req(4'd10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
      tick("bge");
      chk("bge_done", {31'd0, done_o}, 32'd1);
      req(4'd7, 32'd7, 32'd7, 32'd0, 1'b1);
      tick("beq");
      chk("beq_done", {31'd0, done_o}, 32'd1);
      req(4'd8, 32'd7, 32'd7, 32'd0, 1'b0);
      tick("bne");
      chk("bne_done", {31'd0, done_o}, 32'd1);
      req(4'd0, 32'd7, 32'd7, 32'd14, 1'b0);
      tick("add2");
      chk("add2_done", {31'd0, done_o}, 32'd1);

      // Reserved op then hold
      req(4'd13, 32'h1234_5678, 32'h0000_0005, 32'd0, 1'b0);
      tick("rsv");
      chk("rsv_done", {31'd0, done_o}, 32'd1);
      start_i = 1'b0;
      repeat (10) begin
         tick("hold");
         chk("hold_done", {31'd0, done_o}, 32'd0);
         chk("hold_result", alu_result_o, last_exp.res);
         chk("hold_bcond", {31'd0, alu_bcond_o}, {31'd0, last_exp.bc});
      end

      chk("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
